// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synchronises and glitch-filters encoder phases A/B, then
// turns filtered phase transitions into a one-cycle count-enable pulse (step)
// plus a held direction level (down). Transitions where both phases change
// at once set a sticky error flag instead of counting.
//
// Build option: define QUADRATURE_DECODER_X4_EN to step on every valid
// transition (x4). Left undefined, only 01->00 (forward) and 00->01
// (reverse) step (x1).
//
// state_dbg exposes the FSM: 0 = INIT (settling after reset), 1 = RUN.
module quadrature_decoder #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       a,
  input  logic       b,
  input  logic       err_clr,
  output logic       step,
  output logic       down,
  output logic       err,
  output logic [1:0] ab,
  output logic       state_dbg
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  localparam int IW = $clog2(FILTER_LEN + 3);
  localparam logic [IW-1:0] INIT_LAST = IW'(FILTER_LEN + 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [1:0]          sync1;     // first synchroniser stage, {a, b}
  logic [1:0]          sync2;     // synchronised phases {a_s, b_s}
  logic [1:0][CW-1:0]  flt_cnt;   // per-phase disagreement run length
  logic [IW-1:0]       init_cnt;
  logic [1:0]          ab_prev;   // filtered phases one cycle ago

  logic [1:0]          moved;
  logic                illegal;
  logic                fwd;
  logic                rev;
  logic                count;

  assign state_dbg = (state == RUN);

  // Two-flop synchroniser for both asynchronous phases.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
    end
  end

  // Per-phase glitch filter; during INIT the filtered value tracks the
  // synchronised value directly so RUN starts from the real encoder position.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ab      <= 2'b00;
      flt_cnt <= '0;
    end else if (state == INIT) begin
      ab      <= sync2;
      flt_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == ab[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CNT_LAST) begin
          ab[i]      <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Classify the filtered transition seen between ab_prev and ab.
  always_comb begin
    moved   = ab_prev ^ ab;
    illegal = &moved;
    fwd     = (ab_prev == 2'b00 && ab == 2'b10) ||
              (ab_prev == 2'b10 && ab == 2'b11) ||
              (ab_prev == 2'b11 && ab == 2'b01) ||
              (ab_prev == 2'b01 && ab == 2'b00);
    // Exactly one phase moved and it was not a forward move.
    rev     = (^moved) && !fwd;
`ifdef QUADRATURE_DECODER_X4_EN
    count   = fwd || rev;
`else
    count   = (fwd && ab_prev == 2'b01 && ab == 2'b00) ||
              (rev && ab_prev == 2'b00 && ab == 2'b01);
`endif
  end

  // Control FSM: settle for FILTER_LEN+2 cycles after reset, then decode.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= INIT;
      init_cnt <= '0;
      ab_prev  <= 2'b00;
      step     <= 1'b0;
      down     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          step    <= 1'b0;
          ab_prev <= sync2;
          err     <= err & ~err_clr;
          if (init_cnt == INIT_LAST) begin
            state <= RUN;
          end else begin
            init_cnt <= init_cnt + IW'(1);
          end
        end
        RUN: begin
          ab_prev <= ab;
          step    <= count;
          if (count) begin
            down <= rev;
          end
          // A new illegal transition wins over a simultaneous clear.
          err <= (err & ~err_clr) | illegal;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder (FILTER_LEN = 3): directed scenarios followed
// by a randomized phase walk, all compared cycle by cycle against a
// reference model built from phase positions around the electrical cycle.
module tb_quadrature_decoder;

  localparam int FL = 3;
`ifdef QUADRATURE_DECODER_X4_EN
  localparam bit X4 = 1'b1;
`else
  localparam bit X4 = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       err_clr = 1'b0;
  logic       step;
  logic       down;
  logic       err;
  logic [1:0] ab;
  logic       state_dbg;

  always #5 clk = ~clk;

  quadrature_decoder #(.FILTER_LEN(FL)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .a         (a),
    .b         (b),
    .err_clr   (err_clr),
    .step      (step),
    .down      (down),
    .err       (err),
    .ab        (ab),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_steps = 0;
  int last_step_cyc = 0;
  int chg_cyc = 0;
  bit ab_nonzero = 1'b0;
  bit rand_clr_en = 1'b0;

  // Expected {run, ab, err, down, step} after each edge.
  logic [5:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [1:0] m_sync_q[$];   // raw samples still inside the synchroniser
  logic [1:0] m_win[$];      // last FL synchronised samples seen in RUN
  bit         m_run;
  int         m_init_n;
  logic [1:0] m_ab;
  logic [1:0] m_ab_prev;
  bit         m_step;
  bit         m_down;
  bit         m_err;

  // Position of a phase pair around the forward cycle 00,10,11,01.
  function automatic int phase_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_step();
    logic [1:0] seen;
    int         d;
    bit         illegal;
    bit         differ;
    if (!nrst) begin
      m_sync_q = '{2'b00, 2'b00};
      m_win.delete();
      m_run     = 1'b0;
      m_init_n  = 0;
      m_ab      = 2'b00;
      m_ab_prev = 2'b00;
      m_step    = 1'b0;
      m_down    = 1'b0;
      m_err     = 1'b0;
    end else begin
      m_sync_q.push_back({a, b});
      seen    = m_sync_q.pop_front();
      m_step  = 1'b0;
      illegal = 1'b0;
      if (!m_run) begin
        m_ab      = seen;
        m_ab_prev = seen;
        m_err     = m_err && !err_clr;
        m_win.delete();
        m_init_n++;
        if (m_init_n == FL + 2) m_run = 1'b1;
      end else begin
        if (m_ab != m_ab_prev) begin
          d = (phase_pos(m_ab) - phase_pos(m_ab_prev) + 4) % 4;
          if (d == 2) begin
            illegal = 1'b1;
          end else if (X4 || (m_ab_prev == 2'b01 && m_ab == 2'b00) ||
                             (m_ab_prev == 2'b00 && m_ab == 2'b01)) begin
            m_step = 1'b1;
            m_down = (d == 3);
          end
        end
        m_err     = (m_err && !err_clr) || illegal;
        m_ab_prev = m_ab;
        // A phase moves once FL consecutive samples all disagree with it.
        m_win.push_back(seen);
        if (m_win.size() > FL) void'(m_win.pop_front());
        for (int p = 0; p < 2; p++) begin
          differ = (m_win.size() == FL);
          foreach (m_win[j]) if (m_win[j][p] == m_ab[p]) differ = 1'b0;
          if (differ) m_ab[p] = seen[p];
        end
      end
    end
    exp_q.push_back({m_run, m_ab, m_err, m_down, m_step});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: model at the edge, compare on the falling edge.
  task automatic tick();
    logic [5:0] e;
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    check("state", state_dbg, e[5]);
    check("ab",    ab,        e[4:3]);
    check("err",   err,       e[2]);
    check("down",  down,      e[1]);
    check("step",  step,      e[0]);
    if (step) begin
      n_steps++;
      last_step_cyc = cyc;
    end
    if (ab != 2'b00) ab_nonzero = 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic hold_ab(input logic [1:0] v, input int n);
    {a, b}  = v;
    chg_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (rand_clr_en) err_clr = ($urandom_range(0, 7) == 0);
      tick();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] cur;
    logic [1:0] v;
    int         kind;
    int         bit_sel;

    // Reset with both phases high.
    nrst = 1'b0;
    {a, b} = 2'b11;
    repeat (3) tick();
    check("rst_step", step, 0);
    check("rst_down", down, 0);
    check("rst_err",  err, 0);
    check("rst_ab",   ab, 2'b00);
    check("rst_fsm",  state_dbg, 0);

    // Release with a=b=1 held: INIT lasts exactly FL+2 cycles, no steps.
    nrst    = 1'b1;
    n_steps = 0;
    repeat (FL + 1) tick();
    check("init_still", state_dbg, 0);
    tick();
    check("init_done", state_dbg, 1);
    repeat (15) tick();
    check("hold11_steps", n_steps, 0);
    check("hold11_err",   err, 0);
    check("hold11_ab",    ab, 2'b11);

    // Move to 00, then a full forward cycle.
    hold_ab(2'b01, 10);
    hold_ab(2'b00, 10);
    n_steps = 0;
    hold_ab(2'b10, 10);
    hold_ab(2'b11, 10);
    hold_ab(2'b01, 10);
    hold_ab(2'b00, 10);
    check("fwd_steps", n_steps, X4 ? 4 : 1);
    check("fwd_down",  down, 0);
    // Input applied before edge chg_cyc+1; pulse FL+2 edges after that.
    check("fwd_latency", last_step_cyc - chg_cyc, FL + 3);

    // Reverse cycle.
    n_steps = 0;
    hold_ab(2'b01, 10);
    check("rev_latency", last_step_cyc - chg_cyc, FL + 3);
    hold_ab(2'b11, 10);
    hold_ab(2'b10, 10);
    hold_ab(2'b00, 10);
    check("rev_steps", n_steps, X4 ? 4 : 1);
    check("rev_down",  down, 1);
    hold_ab(2'b00, 10);
    check("rev_down_held", down, 1);

    // Short pulses on A: 2 cycles is a glitch, 3 cycles passes.
    n_steps    = 0;
    ab_nonzero = 1'b0;
    hold_ab(2'b10, 2);
    hold_ab(2'b00, 10);
    check("glitch2_ab_moved", ab_nonzero, 0);
    check("glitch2_steps", n_steps, 0);
    n_steps = 0;
    hold_ab(2'b10, 3);
    hold_ab(2'b00, 3);
    check("pulse3_ab",    ab, 2'b10);
    check("pulse3_steps", n_steps, X4 ? 1 : 0);
    check("pulse3_down",  down, X4 ? 0 : 1);
    hold_ab(2'b00, 10);

    // Both phases at once: flagged, not counted.
    n_steps = 0;
    hold_ab(2'b11, 10);
    check("ill_ab",    ab, 2'b11);
    check("ill_err",   err, 1);
    check("ill_steps", n_steps, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_err", err, 0);
    // Illegal 11->00 decoded on the same edge err_clr is sampled.
    {a, b} = 2'b00;
    repeat (FL + 2) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ill_clr_err",   err, 1);
    check("ill_clr_ab",    ab, 2'b00);
    check("ill_clr_steps", n_steps, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Reset lands on the edge where 01->00 would step.
    hold_ab(2'b01, 10);
    n_steps = 0;
    {a, b} = 2'b00;
    repeat (FL + 2) tick();
    nrst = 1'b0;
    tick();
    check("rst_mid_step",  step, 0);
    check("rst_mid_down",  down, 0);
    check("rst_mid_err",   err, 0);
    check("rst_mid_ab",    ab, 2'b00);
    check("rst_mid_fsm",   state_dbg, 0);
    check("rst_mid_steps", n_steps, 0);
    nrst = 1'b1;
    repeat (FL + 1) tick();
    check("rst_mid_init", state_dbg, 0);
    tick();
    check("rst_mid_run", state_dbg, 1);
    n_steps = 0;
    hold_ab(2'b01, 10);
    check("resume_steps", n_steps, 1);
    check("resume_down",  down, 1);

    // Randomized walk: valid steps, short excursions, illegal jumps,
    // random clears and occasional resets.
    rand_clr_en = 1'b1;
    for (int seg = 0; seg < 300; seg++) begin
      cur  = {a, b};
      kind = $urandom_range(0, 99);
      if (kind < 3) begin
        nrst = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
        nrst = 1'b1;
      end else if (kind < 12) begin
        hold_ab(cur ^ 2'b11, $urandom_range(1, 10));
      end else if (kind < 30) begin
        v       = cur;
        bit_sel = $urandom_range(0, 1);
        v[bit_sel] = ~v[bit_sel];
        hold_ab(v, $urandom_range(1, 4));
        hold_ab(cur, $urandom_range(1, 6));
      end else begin
        v       = cur;
        bit_sel = $urandom_range(0, 1);
        v[bit_sel] = ~v[bit_sel];
        hold_ab(v, $urandom_range(1, 12));
      end
    end
    rand_clr_en = 1'b0;
    err_clr     = 1'b0;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
